// File: rtl/baseball_game_ctrl_if.sv
// Event handshake, base-tracker link and game status for baseball_game_ctrl.
// Ports: ev_valid/ev_code/ev_ready (event offer), base_in/hit/base_rst_n (tracker),
//        balls/strikes/outs/inning/bottom/score_away/score_home/game_over (status).
interface baseball_game_ctrl_if #(
  parameter int SCORE_W = 8,
  parameter int INN_W   = 5
);
  logic               ev_valid;
  logic [2:0]         ev_code;
  logic               ev_ready;
  logic [2:0]         base_in;
  logic [3:0]         hit;
  logic               base_rst_n;
  logic [1:0]         balls;
  logic [1:0]         strikes;
  logic [1:0]         outs;
  logic [INN_W-1:0]   inning;
  logic               bottom;
  logic [SCORE_W-1:0] score_away;
  logic [SCORE_W-1:0] score_home;
  logic               game_over;

  modport master (
    output ev_valid, ev_code, base_in,
    input  ev_ready, hit, base_rst_n, balls, strikes, outs, inning, bottom,
           score_away, score_home, game_over
  );

  modport slave (
    input  ev_valid, ev_code, base_in,
    output ev_ready, hit, base_rst_n, balls, strikes, outs, inning, bottom,
           score_away, score_home, game_over
  );
endinterface

// File: rtl/baseball_game_ctrl.sv
// Game sequencer on top of the base-runner tracker: count, outs, innings, scores, end of game.
// Ports: clk, reset_n (async active-low), bus (slave side of baseball_game_ctrl_if).
// One event per IDLE cycle; hits/walks stall one cycle (SETTLE), third out one cycle (SIDE).
module baseball_game_ctrl #(
  parameter int INNINGS = 9,
  parameter int SCORE_W = 8,
  parameter int INN_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  baseball_game_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SIDE, OVER} state_e;

  localparam logic [2:0] EV_BALL   = 3'd0;
  localparam logic [2:0] EV_STRIKE = 3'd1;
  localparam logic [2:0] EV_FOUL   = 3'd2;
  localparam logic [2:0] EV_OUT    = 3'd3;

  state_e             state_q, state_d;
  logic [1:0]         balls_q, balls_d;
  logic [1:0]         strikes_q, strikes_d;
  logic [1:0]         outs_q, outs_d;
  logic [INN_W-1:0]   inning_q, inning_d;
  logic               bottom_q, bottom_d;
  logic [SCORE_W-1:0] away_q, away_d;
  logic [SCORE_W-1:0] home_q, home_d;
  logic [3:0]         hit_q, hit_d;
  logic               base_rst_n_q, base_rst_n_d;

  logic               accept;
  logic               late;
  logic               out_evt;
  logic               credit;
  logic [2:0]         occ_cnt;
  logic [2:0]         runs;
  logic [SCORE_W-1:0] bat_score;
  logic [SCORE_W+2:0] bat_sum;
  logic [SCORE_W-1:0] bat_new;

  assign accept = bus.ev_valid && (state_q == IDLE);
  // Regulation or extra innings: end-of-game rules apply from here on.
  assign late   = int'(inning_q) >= INNINGS;

  assign occ_cnt = {2'b00, bus.base_in[2]} + {2'b00, bus.base_in[1]} + {2'b00, bus.base_in[0]};

  // Runs scoring on this event, from occupancy at acceptance; base_in[0] is third base.
  always_comb begin
    runs = 3'd0;
    case (bus.ev_code)
      EV_BALL: runs = {2'b00, &bus.base_in};   // only a bases-loaded walk forces a run
      3'd4:    runs = {2'b00, bus.base_in[0]};
      3'd5:    runs = {2'b00, bus.base_in[1]} + {2'b00, bus.base_in[0]};
      3'd6:    runs = occ_cnt;
      3'd7:    runs = occ_cnt + 3'd1;
      default: runs = 3'd0;
    endcase
  end

  // Batting team's new score, saturating at all-ones.
  assign bat_score = bottom_q ? home_q : away_q;
  assign bat_sum   = {3'b000, bat_score} + {{SCORE_W{1'b0}}, runs};
  assign bat_new   = (bat_sum[SCORE_W+2:SCORE_W] != 3'b000) ? '1 : bat_sum[SCORE_W-1:0];

  always_comb begin
    state_d      = state_q;
    balls_d      = balls_q;
    strikes_d    = strikes_q;
    outs_d       = outs_q;
    inning_d     = inning_q;
    bottom_d     = bottom_q;
    away_d       = away_q;
    home_d       = home_q;
    hit_d        = 4'b0000;
    base_rst_n_d = 1'b1;
    out_evt      = 1'b0;
    credit       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.ev_code)
            EV_BALL: begin
              if (balls_q == 2'd3) begin
                hit_d  = 4'b1000;  // walk moves runners like a single
                credit = 1'b1;
              end else begin
                balls_d = balls_q + 2'd1;
              end
            end
            EV_STRIKE: begin
              if (strikes_q == 2'd2) out_evt = 1'b1;
              else                   strikes_d = strikes_q + 2'd1;
            end
            EV_FOUL: begin
              if (strikes_q < 2'd2) strikes_d = strikes_q + 2'd1;
            end
            EV_OUT: out_evt = 1'b1;
            default: begin
              hit_d  = 4'b1000 >> bus.ev_code[1:0];  // 4..7 -> single..home run
              credit = 1'b1;
            end
          endcase

          if (credit) begin
            balls_d   = 2'd0;
            strikes_d = 2'd0;
            state_d   = SETTLE;
            if (bottom_q) home_d = bat_new;
            else          away_d = bat_new;
          end

          if (out_evt) begin
            balls_d   = 2'd0;
            strikes_d = 2'd0;
            outs_d    = outs_q + 2'd1;
            if (outs_q == 2'd2) begin
              state_d      = SIDE;
              base_rst_n_d = 1'b0;  // tracker clear lines up with the SIDE cycle
            end
          end
        end
      end

      // Score registered last cycle; a home lead here in a late bottom half is a walk-off.
      SETTLE: state_d = (bottom_q && late && (home_q > away_q)) ? OVER : IDLE;

      SIDE: begin
        balls_d   = 2'd0;
        strikes_d = 2'd0;
        outs_d    = 2'd0;
        state_d   = IDLE;
        if (!bottom_q) begin
          if (late && (home_q > away_q)) state_d  = OVER;  // home already ahead: skip bottom
          else                           bottom_d = 1'b1;
        end else begin
          if (late && (home_q != away_q)) begin
            state_d = OVER;
          end else begin
            bottom_d = 1'b0;
            inning_d = inning_q + INN_W'(1);
          end
        end
      end

      default: state_d = state_q;  // OVER holds until reset
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      balls_q      <= 2'd0;
      strikes_q    <= 2'd0;
      outs_q       <= 2'd0;
      inning_q     <= INN_W'(1);
      bottom_q     <= 1'b0;
      away_q       <= '0;
      home_q       <= '0;
      hit_q        <= 4'b0000;
      base_rst_n_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      balls_q      <= balls_d;
      strikes_q    <= strikes_d;
      outs_q       <= outs_d;
      inning_q     <= inning_d;
      bottom_q     <= bottom_d;
      away_q       <= away_d;
      home_q       <= home_d;
      hit_q        <= hit_d;
      base_rst_n_q <= base_rst_n_d;
    end
  end

  assign bus.ev_ready   = (state_q == IDLE);
  assign bus.game_over  = (state_q == OVER);
  assign bus.hit        = hit_q;
  assign bus.base_rst_n = base_rst_n_q;
  assign bus.balls      = balls_q;
  assign bus.strikes    = strikes_q;
  assign bus.outs       = outs_q;
  assign bus.inning     = inning_q;
  assign bus.bottom     = bottom_q;
  assign bus.score_away = away_q;
  assign bus.score_home = home_q;

endmodule

// File: tb/tb_baseball_game_ctrl.sv
// Bench for baseball_game_ctrl: directed game situations plus random games vs a game-level model.
// Ports: none; drives the controller through a baseball_game_ctrl_if instance.
module tb_baseball_game_ctrl;

  localparam int TB_INNINGS = 2;
  localparam int TB_SCORE_W = 4;
  localparam int TB_INN_W   = 2;
  localparam int SMAX       = (1 << TB_SCORE_W) - 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  baseball_game_ctrl_if #(.SCORE_W(TB_SCORE_W), .INN_W(TB_INN_W)) bus ();

  baseball_game_ctrl #(
    .INNINGS(TB_INNINGS),
    .SCORE_W(TB_SCORE_W),
    .INN_W  (TB_INN_W)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Game-level reference state.
  int m_balls, m_strikes, m_outs, m_inning, m_away, m_home;
  bit m_bottom, m_over;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    m_balls = 0; m_strikes = 0; m_outs = 0; m_inning = 1;
    m_away = 0; m_home = 0; m_bottom = 0; m_over = 0;
  endtask

  // Apply one accepted event to the game; report the expected tracker pulse and stalls.
  task automatic model_apply(input int code, input logic [2:0] b,
                             output int e_hit, output bit e_stall, output bit e_side);
    int runs;
    bit out_evt;
    bit credit;
    e_hit = 0; e_stall = 0; e_side = 0; runs = 0; out_evt = 0; credit = 0;
    case (code)
      0: begin
        m_balls++;
        if (m_balls == 4) begin
          e_hit = 8; credit = 1;
          runs = (b == 3'b111) ? 1 : 0;
        end
      end
      1: begin
        m_strikes++;
        if (m_strikes == 3) out_evt = 1;
      end
      2: if (m_strikes < 2) m_strikes++;
      3: out_evt = 1;
      default: begin
        e_hit = 1 << (7 - code);
        credit = 1;
        case (code)
          4:       runs = int'(b[0]);
          5:       runs = int'(b[1]) + int'(b[0]);
          6:       runs = $countones(b);
          default: runs = $countones(b) + 1;
        endcase
      end
    endcase

    if (credit) begin
      m_balls = 0; m_strikes = 0; e_stall = 1;
      if (m_bottom) m_home = (m_home + runs > SMAX) ? SMAX : m_home + runs;
      else          m_away = (m_away + runs > SMAX) ? SMAX : m_away + runs;
      if (m_bottom && m_inning >= TB_INNINGS && m_home > m_away) m_over = 1;
    end

    if (out_evt) begin
      m_balls = 0; m_strikes = 0; m_outs++;
      if (m_outs == 3) begin
        e_side = 1; e_stall = 1; m_outs = 0;
        if (!m_bottom) begin
          if (m_inning >= TB_INNINGS && m_home > m_away) m_over = 1;
          else m_bottom = 1;
        end else begin
          if (m_inning >= TB_INNINGS && m_home != m_away) m_over = 1;
          else begin
            m_bottom = 0;
            m_inning = (m_inning + 1) % (1 << TB_INN_W);
          end
        end
      end
    end
  endtask

  task automatic cmp_state();
    chk("balls",      32'(bus.balls),      m_balls);
    chk("strikes",    32'(bus.strikes),    m_strikes);
    chk("outs",       32'(bus.outs),       m_outs);
    chk("inning",     32'(bus.inning),     m_inning);
    chk("bottom",     32'(bus.bottom),     32'(m_bottom));
    chk("score_away", 32'(bus.score_away), m_away);
    chk("score_home", 32'(bus.score_home), m_home);
    chk("game_over",  32'(bus.game_over),  32'(m_over));
    chk("ev_ready",   32'(bus.ev_ready),   32'(!m_over));
    chk("base_rst_n", 32'(bus.base_rst_n), 1);
    chk("hit_idle",   32'(bus.hit),        0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_balls",      32'(bus.balls),      0);
    chk("rst_strikes",    32'(bus.strikes),    0);
    chk("rst_outs",       32'(bus.outs),       0);
    chk("rst_inning",     32'(bus.inning),     1);
    chk("rst_bottom",     32'(bus.bottom),     0);
    chk("rst_score_away", 32'(bus.score_away), 0);
    chk("rst_score_home", 32'(bus.score_home), 0);
    chk("rst_hit",        32'(bus.hit),        0);
    chk("rst_base_rst_n", 32'(bus.base_rst_n), 1);
    chk("rst_game_over",  32'(bus.game_over),  0);
    chk("rst_ev_ready",   32'(bus.ev_ready),   1);
  endtask

  task automatic do_reset();
    bus.ev_valid = 1'b0;
    bus.ev_code  = 3'd0;
    bus.base_in  = 3'd0;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // Offer one event while the controller is idle; junk is held on the bus during any stall
  // so that ignored offers are exercised too.
  task automatic do_event(input int code, input logic [2:0] b);
    int e_hit;
    bit e_stall, e_side;
    int stall, rst_low;
    chk("ready_pre", 32'(bus.ev_ready), 1);
    bus.ev_valid = 1'b1;
    bus.ev_code  = 3'(code);
    bus.base_in  = b;
    model_apply(code, b, e_hit, e_stall, e_side);
    @(negedge clk);
    chk("hit", 32'(bus.hit), e_hit);
    stall = 0; rst_low = 0;
    if (!bus.ev_ready) begin
      bus.ev_code = 3'($urandom_range(7, 0));
    end else begin
      bus.ev_valid = 1'b0;
    end
    while (!bus.ev_ready && !bus.game_over && stall < 6) begin
      if (!bus.base_rst_n) rst_low++;
      stall++;
      @(negedge clk);
    end
    bus.ev_valid = 1'b0;
    chk("stall_cycles", stall, 32'(e_stall));
    chk("base_rst_pulse", rst_low, 32'(e_side));
    cmp_state();
  endtask

  task automatic hold_junk(input int n);
    for (int i = 0; i < n; i++) begin
      bus.ev_valid = 1'b1;
      bus.ev_code  = 3'($urandom_range(7, 0));
      bus.base_in  = 3'($urandom_range(7, 0));
      @(negedge clk);
    end
    bus.ev_valid = 1'b0;
    cmp_state();
  endtask

  initial begin
    bus.ev_valid = 1'b0;
    bus.ev_code  = 3'd0;
    bus.base_in  = 3'd0;
    model_reset();
    @(negedge clk);
    chk_reset_vals();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Walk with empty bases, then a bases-loaded walk.
    for (int i = 0; i < 4; i++) do_event(0, 3'b000);
    for (int i = 0; i < 3; i++) do_event(0, 3'($urandom_range(7, 0)));
    do_event(0, 3'b111);
    // Strike, fouls at two strikes, strikeout.
    do_event(1, 3'b000);
    for (int i = 0; i < 3; i++) do_event(2, 3'b000);
    do_event(1, 3'b000);
    // Grand slam and a two-run triple, then the side is retired.
    do_event(7, 3'b111);
    do_event(6, 3'b101);
    do_event(3, 3'b000);
    do_event(3, 3'b000);

    // Score saturation.
    do_reset();
    for (int i = 0; i < 5; i++) do_event(7, 3'b111);

    // Home leads after the top of the last regulation inning: bottom half not played.
    do_reset();
    for (int i = 0; i < 3; i++) do_event(3, 3'b000);
    do_event(7, 3'b000);
    for (int i = 0; i < 6; i++) do_event(3, 3'b000);
    hold_junk(3);

    // Walk-off home run with one out; outs stay frozen.
    do_reset();
    for (int i = 0; i < 10; i++) do_event(3, 3'b000);
    do_event(7, 3'b000);
    hold_junk(3);

    // Scoreless extra innings through the inning-counter wrap.
    do_reset();
    for (int i = 0; i < 24; i++) do_event(3, 3'b000);

    // Reset during the settle cycle of a double.
    do_reset();
    bus.ev_valid = 1'b1;
    bus.ev_code  = 3'd5;
    bus.base_in  = 3'b011;
    @(negedge clk);
    bus.ev_valid = 1'b0;
    chk("midrst_hit_pre", 32'(bus.hit), 4);
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);

    // Random games.
    for (int g = 0; g < 20; g++) begin
      do_reset();
      for (int e = 0; e < 150 && !m_over; e++)
        do_event(int'($urandom_range(7, 0)), 3'($urandom_range(7, 0)));
      if (m_over) hold_junk(2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
